// File: rtl/base2_to_radix_pkg.sv
// Shared helpers and state encoding for the binary-to-radix converter family.
package base_conv_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Smallest n with radix^n >= 2^width.
  function automatic int unsigned ndigits_for(input int unsigned width, input int unsigned radix);
    longint unsigned p;
    int unsigned n;
    p = 1;
    n = 0;
    while (p < (64'd1 << width)) begin
      p = p * radix;
      n++;
    end
    return n;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CONV = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/base2_to_radix_divmod.sv
// Combinational divide/modulo by the constant RADIX, one quotient digit per use.
module radix_divmod
  import base_conv_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned RADIX = 3,
  localparam int unsigned DIGIT_W = clog2(RADIX)
) (
  input  logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   quo,
  output logic [DIGIT_W-1:0] rem
);

  // Widened so RADIX is representable even when WIDTH is narrower than the radix.
  localparam int unsigned XW = WIDTH + 5;
  localparam logic [XW-1:0] DIV = XW'(RADIX);

  always_comb begin
    quo = WIDTH'(XW'(q) / DIV);
    rem = DIGIT_W'(XW'(q) % DIV);
  end

endmodule

// File: rtl/base2_to_radix.sv
// Iterative binary to base-RADIX converter, one digit per clock, LSD packed at the LSBs.
// BASE2_TO_RADIX_FIXED_LAT_EN: always run NDIGITS conversion cycles (constant latency).
module base2_to_radix
  import base_conv_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned RADIX = 3,
  localparam int unsigned DIGIT_W = clog2(RADIX),
  localparam int unsigned NDIGITS = ndigits_for(WIDTH, RADIX),
  localparam int unsigned CNT_W = clog2(NDIGITS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [WIDTH-1:0]             base2_no,
  output logic                         busy,
  output logic                         done,
  output logic [NDIGITS*DIGIT_W-1:0]   base_no,
  output logic [CNT_W-1:0]             ndigits
);

  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(NDIGITS - 1);

  state_t             state, state_next;
  logic [WIDTH-1:0]   q, quo;
  logic [DIGIT_W-1:0] rem;
  logic [CNT_W-1:0]   idx, sig;
  logic               last_step;

  radix_divmod #(.WIDTH(WIDTH), .RADIX(RADIX)) u_divmod (
    .q   (q),
    .quo (quo),
    .rem (rem)
  );

  always_comb begin
`ifdef BASE2_TO_RADIX_FIXED_LAT_EN
    last_step = (idx == IDX_LAST);
`else
    last_step = (quo == '0) || (idx == IDX_LAST);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (en) state_next = ST_CONV;
      ST_CONV: if (last_step) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // sig tracks the highest non-zero digit so the count stays right under fixed latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      idx     <= '0;
      sig     <= '0;
      base_no <= '0;
      ndigits <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            q       <= base2_no;
            base_no <= '0;
            idx     <= '0;
            sig     <= CNT_W'(1);
          end
        end
        ST_CONV: begin
          base_no[idx*DIGIT_W +: DIGIT_W] <= rem;
          q   <= quo;
          idx <= idx + 1'b1;
          if (q != '0) sig <= idx + 1'b1;
          if (last_step) ndigits <= (q != '0) ? idx + 1'b1 : sig;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/base2_to_radix.md
Name: base2_to_radix

Overview:
- Parametrised successor to the fixed base-3 converter.
- Converts an unsigned WIDTH-bit binary number into base RADIX (2..16), producing one digit per clock by iterative divide/modulo by RADIX.
- Result digits are packed least-significant digit at the LSBs, so no final alignment shift is needed.
- Adds async reset, busy/done handshake and a significant-digit count. Sits between a binary datapath and a digit display/serialiser.

Parameters:
- WIDTH, 16, input binary width (2..32).
- RADIX, 3, target base (2..16).
- DIGIT_W, clog2(RADIX), bits per packed digit (derived; do not override).
- NDIGITS, smallest n with RADIX^n >= 2^WIDTH, maximum digit count (derived; 11 for 16/3).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  start request; sampled only in IDLE.
- base2_no  in  WIDTH  binary operand; captured on the accepted start edge.
- busy  out  1  high from the accept edge until done deasserts.
- done  out  1  one-cycle pulse; result valid.
- base_no  out  NDIGITS*DIGIT_W  packed digits; digit i at [i*DIGIT_W +: DIGIT_W].
- ndigits  out  clog2(NDIGITS+1)  count of significant digits (>=1).

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, base_no=0, ndigits=0, internal quotient/index=0.
- Reset during CONV or DONE aborts the conversion immediately. The first en after release starts a fresh conversion.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - en=1 at edge T0 -> latch q=base2_no, clear base_no, idx=0, busy=1, go to CONV.
  - en=0 -> stay in IDLE.
- CONV, each edge:
  - base_no digit[idx] = q % RADIX; q = q / RADIX; idx++.
  - If the new q==0 or idx reaches NDIGITS -> ndigits=idx, go to DONE.
- Digit k is written at edge Tk. done=1 during the cycle after the last digit edge, exactly one cycle.
- DONE -> IDLE on the next edge; busy falls with done.
- Latency: done is high in cycle T0+k, where k = significant digits (k=1 for input 0).
- Input 0: one CONV cycle writes digit 0, ndigits=1, base_no=0.
- en while busy is ignored, including en held high. Back-to-back: en high in the cycle after done starts the next conversion.
- base_no and ndigits hold their values until the next accepted start. The next start clears base_no.
- Unused upper digit fields read 0.
- Divide/modulo is combinational by constant RADIX inside one cycle. Remainder width DIGIT_W, quotient width WIDTH.

Optional Feature:
- Macro BASE2_TO_RADIX_FIXED_LAT_EN.
- Defined:
  - CONV always runs NDIGITS cycles; leading digits are 0.
  - done always at T0+NDIGITS, for constant-latency pipelines.
  - ndigits still reports the significant count.
- Undefined: early termination as above.

Decomposition:
- Package base_conv_pkg holds:
  - constant functions clog2 and ndigits_for(WIDTH, RADIX);
  - state encoding constants ST_IDLE=2'b00, ST_CONV=2'b01, ST_DONE=2'b10.
- One sub-module, radix_divmod: combinational q/RADIX and q%RADIX, parameters WIDTH and RADIX. It replaces the generic divider so the constant divisor can be optimised.
- The top holds the FSM, digit index and output registers.

Test Plan:
- WIDTH=16, RADIX=3, base2_no=10, en pulse at T0:
  - digits 1,0,1 (10 = 101 in base 3); base_no=6'b01_00_01, upper bits 0; ndigits=3;
  - done high in cycle T0+3 only; busy high T0..T0+3.
- base2_no=65535, RADIX=3:
  - base_no digits MSD->LSD = 1,0,0,2,2,2,2,0,0,2,0; ndigits=11; done at T0+11.
- base2_no=0 -> ndigits=1, base_no=0, done at T0+1.
- RADIX=10 instance, base2_no=1234 -> base_no[15:0]=16'h1234, ndigits=4.
- en held high continuously with operand changing mid-conversion:
  - the result uses the T0 value only;
  - the next conversion starts the cycle after done.
- rst_n low at T0+2 of a conversion of 65535:
  - outputs 0 immediately (asynchronously);
  - no done pulse;
  - after release, converting 10 gives the correct result.
- With BASE2_TO_RADIX_FIXED_LAT_EN, base2_no=10:
  - done at T0+11; ndigits=3; digits 3..10 are 0.
